dense_argmax: RTL
=================

# dense_argmax

Classifier head that sits directly downstream of the dense layer. When the dense layer signals completion, this block snapshots the N flattened Q1.15 outputs and scans them one per cycle. It then presents the winning class index and score on a valid/ready output port. Optionally, it also reports the confidence margin to the runner-up.

## Interface
- N, 100, number of Q1.15 scores on the input bus (≥1)
- IDX_W, 7, class-index width; must satisfy 2^IDX_W ≥ N
- clk, input, 1, clock
- rst, input, 1, reset: asynchronous, active-high
- y_in, input, 16*N, flattened scores; word k at bits [16k+15:16k], signed Q1.15
- in_valid, input, 1, level "scores ready" (driven by the dense layer's resting); the start trigger is its rising edge
- out_ready, input, 1, consumer accepts the result
- class_idx, output, IDX_W, index of the maximum score
- max_val, output, 16, maximum score (signed Q1.15)
- margin, output, 16, max minus second-max (only with DENSE_ARGMAX_MARGIN_EN)
- out_valid, output, 1, result valid
- busy, output, 1, high in SCAN or DONE

## Operation
- Edge detect: in_valid_q registers in_valid and resets to 0. start = in_valid & ~in_valid_q.
  - If in_valid is already high when reset releases, that counts as a start.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On start, copy y_in into a snapshot array, set best=snap[0], best_idx=0, cnt=1.
  - Next state is SCAN if N>1, DONE if N==1.
- SCAN, each cycle:
  - If snap[cnt] > best (signed, strict), then best←snap[cnt] and best_idx←cnt.
  - cnt increments. When cnt==N-1, the next state is DONE.
- Ties: the lowest index wins.
- DONE:
  - out_valid=1. class_idx, max_val and margin are held stable.
  - On out_valid & out_ready, go to IDLE.
- Starts seen in SCAN or DONE are ignored and not queued. in_valid falling mid-scan has no effect, because the scan uses the snapshot.
- busy = (state != IDLE).
- Reset values: state=IDLE, class_idx=0, max_val=0, margin=0, out_valid=0, busy=0, snapshot=0.
- Reset mid-operation aborts the scan immediately. No partial result is emitted.
- Comparisons are signed 16-bit. 0x8000 is the smallest value and 0x7FFF the largest.

## Timing
- Start sampled at edge T0 (snapshot loaded).
- SCAN occupies edges T0+1 … T0+N-1. out_valid rises after edge T0+N-1, i.e. N cycles of latency; for N=1 it is 1 cycle.
- Outputs are registered. There is no combinational path from y_in or in_valid to any output.
- out_ready is sampled only in DONE. If out_ready is already high when DONE is entered, out_valid is high for exactly one cycle.
- Back-to-back: a new rising edge of in_valid can be accepted in the first IDLE cycle after the handshake.

## Configuration
- DENSE_ARGMAX_MARGIN_EN defined:
  - The block also tracks second (init 0x8000) alongside best.
  - When a score replaces best, second←old best. Otherwise, if the score > second, second←score.
  - margin = best − second, computed at 17 bits and saturated to 0x7FFF. It is 0x7FFF for N=1 and 0 on an exact tie.
  - margin resets to 0.
- Undefined: the margin port, the second register and the subtractor are absent. All other behaviour is identical.

## Structure
- Shared package dense_pkg:
  - q15_t (signed 16-bit) typedef.
  - Q15_MAX=16'sh7FFF and Q15_MIN=16'sh8000.
  - argmax_state_t enum {IDLE, SCAN, DONE}.
- One sub-module, argmax_cmp: combinational compare/update taking best, best_idx, second, the candidate score and its index, and returning the updated best, best_idx and second. It is instantiated once in the FSM datapath.

## Test plan
- N=4, y_in={0x0100,0x7FFF,0x8000,0x0200} (idx0..3), rising edge of in_valid with out_ready=1 → after 4 cycles, class_idx=1, max_val=0x7FFF, one-cycle out_valid; with margin enabled, margin=0x7DFF.
- All N=100 scores = 0xF000 → class_idx=0, max_val=0xF000, margin=0 (tie goes to the lowest index).
- N=4, scores {0x8000,0x8000,0x8000,0x7FFF} → class_idx=3; margin saturates to 0x7FFF (true difference 0xFFFF).
- Hold out_ready=0 for 10 cycles in DONE, toggle in_valid twice and change y_in → outputs stable and no restart; out_ready=1 → IDLE, and a later edge starts a fresh scan on the new data.
- Assert rst at cycle 20 of a 100-score scan → all outputs 0 and IDLE immediately; in_valid held high through reset release → scan restarts and completes after 100 cycles.
- N=1, y_in=0x4000 → out_valid 1 cycle after the start, class_idx=0, max_val=0x4000, margin=0x7FFF.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types for the dense-layer classifier head: Q1.15 score type,
// saturation limits, argmax FSM states and the margin saturation helper.
package dense_pkg;

    typedef logic signed [15:0] q15_t;

    localparam q15_t Q15_MAX = 16'sh7FFF;
    localparam q15_t Q15_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_t;

    // best >= second always holds, so only the positive overflow needs clamping.
    function automatic q15_t sat_margin(input q15_t best, input q15_t second);
        logic signed [16:0] diff;
        diff = $signed({best[15], best}) - $signed({second[15], second});
        return (diff > 17'sd32767) ? Q15_MAX : q15_t'(diff[15:0]);
    endfunction

endpackage

// File: rtl/dense_argmax_cmp.sv
// argmax_cmp: combinational best/second update for one candidate score.
// Second-best tracking exists only when DENSE_ARGMAX_MARGIN_EN is defined.
module argmax_cmp
    import dense_pkg::*;
#(
    parameter int unsigned IDX_W = 7
) (
    input  q15_t             best_i,
    input  logic [IDX_W-1:0] best_idx_i,
`ifdef DENSE_ARGMAX_MARGIN_EN
    input  q15_t             second_i,
    output q15_t             second_o,
`endif
    input  q15_t             cand_i,
    input  logic [IDX_W-1:0] cand_idx_i,
    output q15_t             best_o,
    output logic [IDX_W-1:0] best_idx_o
);

    always_comb begin
        best_o     = best_i;
        best_idx_o = best_idx_i;
`ifdef DENSE_ARGMAX_MARGIN_EN
        second_o   = second_i;
`endif
        // Strict compare keeps the earliest index on ties.
        if (cand_i > best_i) begin
            best_o     = cand_i;
            best_idx_o = cand_idx_i;
`ifdef DENSE_ARGMAX_MARGIN_EN
            second_o   = best_i;
        end else if (cand_i > second_i) begin
            second_o   = cand_i;
`endif
        end
    end

endmodule

// File: rtl/dense_argmax.sv
// dense_argmax: snapshots N Q1.15 scores on the rising edge of in_valid, scans
// one per cycle and presents the argmax on a valid/ready port.
// Optional margin output enabled by DENSE_ARGMAX_MARGIN_EN.
module dense_argmax
    import dense_pkg::*;
#(
    parameter int unsigned N     = 100,
    parameter int unsigned IDX_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [16*N-1:0]      y_in,
    input  logic                 in_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     class_idx,
    output logic [15:0]          max_val,
`ifdef DENSE_ARGMAX_MARGIN_EN
    output logic [15:0]          margin,
`endif
    output logic                 out_valid,
    output logic                 busy
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    argmax_state_t    state_q;
    q15_t             snap_q [N];
    q15_t             best_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_valid_q;
    logic [IDX_W-1:0] class_idx_q;
    q15_t             max_val_q;

    q15_t             cand;
    logic [IDX_W-1:0] cand_idx;
    q15_t             best_d;
    logic [IDX_W-1:0] best_idx_d;
    logic             start;

`ifdef DENSE_ARGMAX_MARGIN_EN
    q15_t             second_q;
    q15_t             second_d;
    q15_t             margin_q;
`endif

    assign start    = in_valid & ~in_valid_q;
    assign cand_idx = IDX_W'(cnt_q);

    if (N > 1) begin : g_scan
        assign cand = snap_q[cnt_q];
    end else begin : g_single
        assign cand = snap_q[0];
    end

    argmax_cmp #(
        .IDX_W (IDX_W)
    ) u_cmp (
        .best_i     (best_q),
        .best_idx_i (best_idx_q),
`ifdef DENSE_ARGMAX_MARGIN_EN
        .second_i   (second_q),
        .second_o   (second_d),
`endif
        .cand_i     (cand),
        .cand_idx_i (cand_idx),
        .best_o     (best_d),
        .best_idx_o (best_idx_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_valid_q  <= 1'b0;
            best_q      <= '0;
            best_idx_q  <= '0;
            cnt_q       <= '0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            for (int unsigned k = 0; k < N; k++) snap_q[k] <= '0;
`ifdef DENSE_ARGMAX_MARGIN_EN
            second_q    <= Q15_MIN;
            margin_q    <= '0;
`endif
        end else begin
            in_valid_q <= in_valid;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int unsigned k = 0; k < N; k++) snap_q[k] <= y_in[16*k +: 16];
                        best_q     <= y_in[15:0];
                        best_idx_q <= '0;
                        cnt_q      <= CNT_W'(1);
`ifdef DENSE_ARGMAX_MARGIN_EN
                        second_q   <= Q15_MIN;
`endif
                        if (N == 1) begin
                            state_q     <= DONE;
                            class_idx_q <= '0;
                            max_val_q   <= y_in[15:0];
`ifdef DENSE_ARGMAX_MARGIN_EN
                            margin_q    <= Q15_MAX;
`endif
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    cnt_q      <= cnt_q + 1'b1;
`ifdef DENSE_ARGMAX_MARGIN_EN
                    second_q   <= second_d;
`endif
                    // Final element: publish the post-update result directly.
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_q     <= DONE;
                        class_idx_q <= best_idx_d;
                        max_val_q   <= best_d;
`ifdef DENSE_ARGMAX_MARGIN_EN
                        margin_q    <= sat_margin(best_d, second_d);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign class_idx = class_idx_q;
    assign max_val   = max_val_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
`ifdef DENSE_ARGMAX_MARGIN_EN
    assign margin    = margin_q;
`endif

endmodule
